// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MIPS multiply/divide unit that commits into architectural HI/LO.
// Define MDU_MADD_EN to accept MADD/MADDU (0110/0111), which accumulate into {HI,LO}.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [4:0]  cnt;
    logic [63:0] pend, smul, umul, res;
    logic [31:0] a_mag, b_mag, mq, mr, squo, srem, quo, rem;
    logic        is_div, uns, long_op;
`ifdef MDU_MADD_EN
    logic        acc;
`endif

    assign busy   = cnt != 5'd0;
    assign is_div = MDUOp[3:1] == 3'b001;
    assign uns    = MDUOp[0];
`ifdef MDU_MADD_EN
    assign long_op = MDUOp[3:2] == 2'b00 || MDUOp[3:1] == 3'b011;
`else
    assign long_op = MDUOp[3:2] == 2'b00;
`endif

    assign smul = $signed({{32{A1[31]}}, A1}) * $signed({{32{A2[31]}}, A2});
    assign umul = {32'd0, A1} * {32'd0, A2};

    // Signed divide runs on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    assign a_mag = A1[31] ? -A1 : A1;
    assign b_mag = A2[31] ? -A2 : A2;
    assign mq    = a_mag / b_mag;
    assign mr    = a_mag % b_mag;
    assign squo  = (A1[31] ^ A2[31]) ? -mq : mq;
    assign srem  = A1[31] ? -mr : mr;
    assign quo   = A2 == 32'd0 ? 32'hFFFF_FFFF : uns ? A1 / A2 : squo;
    assign rem   = A2 == 32'd0 ? A1 : uns ? A1 % A2 : srem;
    assign res   = is_div ? {rem, quo} : uns ? umul : smul;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            pend <= '0;
            HI   <= '0;
            LO   <= '0;
`ifdef MDU_MADD_EN
            acc  <= 1'b0;
`endif
        end else if (busy) begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1)
`ifdef MDU_MADD_EN
                {HI, LO} <= acc ? {HI, LO} + pend : pend;
`else
                {HI, LO} <= pend;
`endif
        end else if (start) begin
            if (long_op) begin
                cnt  <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                pend <= res;
`ifdef MDU_MADD_EN
                acc  <= MDUOp[2];
`endif
            end else if (MDUOp == 4'b0100) begin
                HI <= A1;
            end else if (MDUOp == 4'b0101) begin
                LO <= A1;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: random and directed stimulus for mdu_seq, checked every cycle against a
// timestamp-based behavioural model of HI/LO/busy.
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] A1 = 32'd0;
    logic [31:0] A2 = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] p_val = 64'd0;
    logic        p_acc = 1'b0;
    logic        pend_v = 1'b0;
    int          edge_n = 0;
    int          commit_at = 0;

    mdu_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .MDUOp(MDUOp),
        .A1(A1), .A2(A2), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [31:0] q, r;
        if (op == 4'd2 || op == 4'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = op == 4'd2 ? 32'(sa / sb) : 32'(ua / ub);
            r = op == 4'd2 ? 32'(sa % sb) : 32'(ua % ub);
            return {r, q};
        end
        return op[0] ? ua * ub : 64'(sa * sb);
    endfunction

    task automatic model_reset();
        m_hi = 32'd0;
        m_lo = 32'd0;
        pend_v = 1'b0;
    endtask

    // Advances the model by one rising edge: commit when the due edge arrives, else accept.
    task automatic step();
        edge_n++;
        if (pend_v) begin
            if (edge_n == commit_at) begin
                {m_hi, m_lo} = p_acc ? {m_hi, m_lo} + p_val : p_val;
                pend_v = 1'b0;
            end
        end else if (start) begin
            case (MDUOp)
                4'd0, 4'd1, 4'd2, 4'd3: begin
                    pend_v = 1'b1;
                    p_acc = 1'b0;
                    p_val = model_result(MDUOp, A1, A2);
                    commit_at = edge_n + (MDUOp >= 4'd2 ? 10 : 5);
                end
`ifdef MDU_MADD_EN
                4'd6, 4'd7: begin
                    pend_v = 1'b1;
                    p_acc = 1'b1;
                    p_val = model_result({3'd0, MDUOp[0]}, A1, A2);
                    commit_at = edge_n + 5;
                end
`endif
                4'd4: m_hi = A1;
                4'd5: m_lo = A1;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(pend_v));
        check("HI", 64'(HI), 64'(m_hi));
        check("LO", 64'(LO), 64'(m_lo));
    end

    task automatic tick();
        @(posedge clk);
        if (reset_n) step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        A1 = a;
        A2 = b;
        tick();
        start = 1'b0;
        A1 = $urandom;
        A2 = $urandom;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n = 0;
        issue(op, a, b);
        while (busy && n < 50) begin
            n++;
            tick();
        end
        check({name, " cycles"}, 64'(n), 64'(cyc));
        check({name, " HI"}, 64'(HI), 64'(ehi));
        check({name, " LO"}, 64'(LO), 64'(elo));
        check({name, " model"}, {m_hi, m_lo}, {ehi, elo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        reset_n = 1'b1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset HI/LO", {HI, LO}, 64'd0);

        run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", 4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 4'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("divu0", 4'd3, 32'h1234, 32'd0, 10, 32'h1234, 32'hFFFF_FFFF);
        run_op("divovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("mtlo", 4'd5, 32'hABCD, 32'd0, 0, 32'd0, 32'hABCD);

        issue(4'd0, 32'd7, 32'd6);
        issue(4'd4, 32'h5555, 32'd0);
        issue(4'd0, 32'd2, 32'd2);
        n = 2;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        check("ignore cycles", 64'(n), 64'd5);
        check("ignore HI/LO", {HI, LO}, {32'd0, 32'd42});
        run_op("b2b", 4'd1, 32'h10, 32'h10, 5, 32'd0, 32'h100);

        run_op("mthi", 4'd4, 32'd0, 32'd0, 0, 32'd0, 32'h100);
        run_op("mtlo2", 4'd5, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", 4'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        run_op("maddu", 4'd7, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif
        run_op("mthi2", 4'd4, 32'h77, 32'd0, 0, 32'h77, LO);

        issue(4'd2, 32'd100, 32'd7);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("async busy", 64'(busy), 64'd0);
        check("async HI/LO", {HI, LO}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (15) tick();
        check("no commit after reset", {31'd0, busy, HI, LO}, 64'd0);

        for (int i = 0; i < 800; i++) begin
            start = $urandom_range(0, 2) == 0;
            MDUOp = 4'($urandom_range(0, 9));
            A1 = pick();
            A2 = pick();
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
